// File: rtl/hub_scan_driver_pkg.sv
// Shared constants and types for the HUB75 scan driver and the frame-buffer writer.
// Frame-buffer words carry three hubs of {B,G,R} triplets; the helpers regroup them per colour.
package hub_scan_driver_pkg;

    localparam int COLS       = 120;
    localparam int SCAN_ROWS  = 30;
    localparam int PLANES     = 8;
    localparam int BASE_TICKS = 16;

    localparam int COL_W      = 7;
    localparam int ROW_W      = 5;
    localparam int PLANE_W    = 3;
    localparam int FB_ADDR_W  = PLANE_W + ROW_W + COL_W;
    localparam int FB_DATA_W  = 27;
    localparam int TICK_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_LATCH    = 3'd3,
        ST_DISPLAY  = 3'd4,
        ST_ADVANCE  = 3'd5
    } scan_state_e;

    function automatic logic [8:0] hub_red(input logic [FB_DATA_W-1:0] d);
        return {d[20:18], d[11:9], d[2:0]};
    endfunction

    function automatic logic [8:0] hub_green(input logic [FB_DATA_W-1:0] d);
        return {d[23:21], d[14:12], d[5:3]};
    endfunction

    function automatic logic [8:0] hub_blue(input logic [FB_DATA_W-1:0] d);
        return {d[26:24], d[17:15], d[8:6]};
    endfunction

endpackage

// File: rtl/hub_scan_driver_oe_timer.sv
// Output-enable timer: one settle cycle after load, then BASE<<plane active cycles.
// last marks the final active cycle so the scan FSM can leave DISPLAY on time.
module hub_scan_driver_oe_timer
    import hub_scan_driver_pkg::*;
#(
    parameter int BASE = BASE_TICKS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PLANE_W-1:0] plane,
    output logic               oe_low,
    output logic               last
);

    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic              settle_q, settle_d;

    // next count: load, hold through the settle cycle, then count down to zero
    always_comb begin
        cnt_d    = cnt_q;
        settle_d = settle_q;
        if (load) begin
            cnt_d    = TICK_W'(BASE) << plane;
            settle_d = 1'b1;
        end else if (settle_q) begin
            settle_d = 1'b0;
        end else if (cnt_q != {TICK_W{1'b0}}) begin
            cnt_d = cnt_q - TICK_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // timer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= {TICK_W{1'b0}};
            settle_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
        end
    end

    assign oe_low = !settle_q && (cnt_q != {TICK_W{1'b0}});
    assign last   = !settle_q && (cnt_q == TICK_W'(1));

endmodule

// File: rtl/hub_scan_driver.sv
// HUB75 scan driver: reads bit-planes from the frame buffer, shifts them to three panel chains,
// latches, and shows each plane for a binary-weighted OE-low time before moving to the next row.
module hub_scan_driver
    import hub_scan_driver_pkg::*;
#(
    parameter int NUM_COLS   = COLS,
    parameter int NUM_ROWS   = SCAN_ROWS,
    parameter int NUM_PLANES = PLANES,
    parameter int NUM_BASE   = BASE_TICKS
) (
    input  logic                 MCLK_IN,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic                 LATCH_POS,
    output logic                 FB_RD_EN,
    output logic [FB_ADDR_W-1:0] FB_RD_ADDR,
    input  logic [FB_DATA_W-1:0] FB_RD_DATA,
    output logic [8:0]           HUB_R,
    output logic [8:0]           HUB_G,
    output logic [8:0]           HUB_B,
    output logic [ROW_W-1:0]     HUB_ADDR,
    output logic                 HUB_CLK,
    output logic                 HUB_LATCH,
    output logic                 HUB_OE,
    output logic                 FRAME_DONE
);

    scan_state_e          state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 phase_q, phase_d;
    logic [PLANE_W-1:0]   plane_q, plane_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 lat_cnt_q, lat_cnt_d;
    logic                 latch_pos_q, latch_pos_d;
    logic                 fb_rd_en_q, fb_rd_en_d;
    logic [FB_ADDR_W-1:0] fb_rd_addr_q, fb_rd_addr_d;
    logic [8:0]           hub_r_q, hub_r_d, hub_g_q, hub_g_d, hub_b_q, hub_b_d;
    logic [ROW_W-1:0]     hub_addr_q, hub_addr_d;
    logic                 hub_clk_q, hub_clk_d;
    logic                 hub_latch_q, hub_latch_d;
    logic                 hub_oe_q, hub_oe_d;
    logic                 frame_done_q, frame_done_d;

    logic col_last_s, plane_last_s, row_last_s;
    logic timer_load_s, oe_low_s, oe_last_s;

    assign col_last_s   = (col_q == COL_W'(NUM_COLS - 1));
    assign plane_last_s = (plane_q == PLANE_W'(NUM_PLANES - 1));
    assign row_last_s   = (row_q == ROW_W'(NUM_ROWS - 1));

    hub_scan_driver_oe_timer #(
        .BASE   (NUM_BASE)
    ) u_oe_timer (
        .clk    (MCLK_IN),
        .rst    (RESET),
        .load   (timer_load_s),
        .plane  (plane_q),
        .oe_low (oe_low_s),
        .last   (oe_last_s)
    );

    // next-state sequencing and next panel outputs
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        phase_d     = phase_q;
        plane_d     = plane_q;
        row_d       = row_q;
        lat_cnt_d   = lat_cnt_q;
        latch_pos_d = latch_pos_q;

        case (state_q)
            ST_IDLE: begin
                if (ENABLE) begin
                    state_d     = ST_PREFETCH;
                    latch_pos_d = LATCH_POS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREFETCH: begin
                state_d = ST_SHIFT;
                col_d   = {COL_W{1'b0}};
                phase_d = 1'b0;
            end
            ST_SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (col_last_s) begin
                        state_d   = latch_pos_q ? ST_LATCH : ST_DISPLAY;
                        lat_cnt_d = 1'b0;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_LATCH: begin
                if (lat_cnt_q) begin
                    state_d = ST_DISPLAY;
                end else begin
                    lat_cnt_d = 1'b1;
                end
            end
            ST_DISPLAY: begin
                if (oe_last_s) begin
                    if (plane_last_s) begin
                        state_d = ST_ADVANCE;
                    end else begin
                        plane_d = plane_q + PLANE_W'(1);
                        state_d = ST_PREFETCH;
                    end
                end else begin
                    state_d = ST_DISPLAY;
                end
            end
            ST_ADVANCE: begin
                plane_d = {PLANE_W{1'b0}};
                row_d   = row_last_s ? {ROW_W{1'b0}} : row_q + ROW_W'(1);
                state_d = ENABLE ? ST_PREFETCH : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        timer_load_s = (state_d == ST_DISPLAY) && (state_q != ST_DISPLAY);

        // reads run one step ahead so each word arrives for the phase0 capture
        if (state_d == ST_PREFETCH) begin
            fb_rd_en_d   = 1'b1;
            fb_rd_addr_d = {plane_d, row_d, {COL_W{1'b0}}};
        end else if ((state_q == ST_SHIFT) && !phase_q && !col_last_s) begin
            fb_rd_en_d   = 1'b1;
            fb_rd_addr_d = {plane_q, row_q, col_q + COL_W'(1)};
        end else begin
            fb_rd_en_d   = 1'b0;
            fb_rd_addr_d = fb_rd_addr_q;
        end

        if ((state_q == ST_SHIFT) && !phase_q) begin
            hub_r_d = hub_red(FB_RD_DATA);
            hub_g_d = hub_green(FB_RD_DATA);
            hub_b_d = hub_blue(FB_RD_DATA);
        end else begin
            hub_r_d = hub_r_q;
            hub_g_d = hub_g_q;
            hub_b_d = hub_b_q;
        end

        hub_clk_d    = (state_q == ST_SHIFT) && phase_q;
        hub_latch_d  = (state_q == ST_LATCH) ||
                       ((state_q == ST_SHIFT) && col_last_s && !latch_pos_q);
        hub_oe_d     = !((state_q == ST_DISPLAY) && oe_low_s);
        hub_addr_d   = row_d;
        frame_done_d = (state_q == ST_ADVANCE) && row_last_s;
    end

    // all state and panel outputs; outputs trail the FSM by one cycle so they move together
    always_ff @(posedge MCLK_IN or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            col_q        <= {COL_W{1'b0}};
            phase_q      <= 1'b0;
            plane_q      <= {PLANE_W{1'b0}};
            row_q        <= {ROW_W{1'b0}};
            lat_cnt_q    <= 1'b0;
            latch_pos_q  <= 1'b0;
            fb_rd_en_q   <= 1'b0;
            fb_rd_addr_q <= {FB_ADDR_W{1'b0}};
            hub_r_q      <= 9'd0;
            hub_g_q      <= 9'd0;
            hub_b_q      <= 9'd0;
            hub_addr_q   <= {ROW_W{1'b0}};
            hub_clk_q    <= 1'b0;
            hub_latch_q  <= 1'b0;
            hub_oe_q     <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            plane_q      <= plane_d;
            row_q        <= row_d;
            lat_cnt_q    <= lat_cnt_d;
            latch_pos_q  <= latch_pos_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_rd_addr_q <= fb_rd_addr_d;
            hub_r_q      <= hub_r_d;
            hub_g_q      <= hub_g_d;
            hub_b_q      <= hub_b_d;
            hub_addr_q   <= hub_addr_d;
            hub_clk_q    <= hub_clk_d;
            hub_latch_q  <= hub_latch_d;
            hub_oe_q     <= hub_oe_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign FB_RD_EN   = fb_rd_en_q;
    assign FB_RD_ADDR = fb_rd_addr_q;
    assign HUB_R      = hub_r_q;
    assign HUB_G      = hub_g_q;
    assign HUB_B      = hub_b_q;
    assign HUB_ADDR   = hub_addr_q;
    assign HUB_CLK    = hub_clk_q;
    assign HUB_LATCH  = hub_latch_q;
    assign HUB_OE     = hub_oe_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_hub_scan_driver.sv
// Bench for hub_scan_driver: a full-size instance checks row timing and data per plane,
// a shrunken instance (4 cols, 8 rows, 3 planes, base 1) checks frame sequencing and ENABLE drop.
module tb_hub_scan_driver;
    import hub_scan_driver_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, lp_a, fb_en_a, hclk_a, lat_a, oe_a, fd_a;
    logic [14:0] fb_addr_a;
    logic [26:0] fb_data_a = 27'd0;
    logic [8:0]  r_a, g_a, b_a;
    logic [4:0]  addr_a;

    logic        rst_b, en_b, lp_b, fb_en_b, hclk_b, lat_b, oe_b, fd_b;
    logic [14:0] fb_addr_b;
    logic [26:0] fb_data_b = 27'd0;
    logic [8:0]  r_b, g_b, b_b;
    logic [4:0]  addr_b;

    hub_scan_driver dut_a (
        .MCLK_IN(clk), .RESET(rst_a), .ENABLE(en_a), .LATCH_POS(lp_a),
        .FB_RD_EN(fb_en_a), .FB_RD_ADDR(fb_addr_a), .FB_RD_DATA(fb_data_a),
        .HUB_R(r_a), .HUB_G(g_a), .HUB_B(b_a), .HUB_ADDR(addr_a),
        .HUB_CLK(hclk_a), .HUB_LATCH(lat_a), .HUB_OE(oe_a), .FRAME_DONE(fd_a)
    );

    hub_scan_driver #(.NUM_COLS(4), .NUM_ROWS(8), .NUM_PLANES(3), .NUM_BASE(1)) dut_b (
        .MCLK_IN(clk), .RESET(rst_b), .ENABLE(en_b), .LATCH_POS(lp_b),
        .FB_RD_EN(fb_en_b), .FB_RD_ADDR(fb_addr_b), .FB_RD_DATA(fb_data_b),
        .HUB_R(r_b), .HUB_G(g_b), .HUB_B(b_b), .HUB_ADDR(addr_b),
        .HUB_CLK(hclk_b), .HUB_LATCH(lat_b), .HUB_OE(oe_b), .FRAME_DONE(fd_b)
    );

    // frame-buffer content encodes its own address, so the column index is visible in the data
    function automatic logic [26:0] pat(input logic [14:0] a);
        return {a, a[11:0]};
    endfunction

    always @(posedge clk) if (fb_en_a) fb_data_a <= pat(fb_addr_a);
    always @(posedge clk) if (fb_en_b) fb_data_b <= pat(fb_addr_b);

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit start;
        bit lp;
        int plane;
        int row;
        int exp_rises;
        int exp_oe_low;
        int exp_latch;
        int exp_latch_clk;
        int exp_latch_after;
    } vec_t;

    vec_t tbl[9];

    // one plane period of dut_a: ends on the first OE-high sample after an OE-low run
    task automatic run_plane(input int plane, input int row,
                             output int rises, output int oe_low, output int latch,
                             output int latch_clk, output int latch_after,
                             output int data_err, output int inv_err, output int addr_err,
                             output int timeout);
        logic       prev_clk;
        logic       seen_low;
        logic [4:0] prev_addr;
        logic [26:0] got;
        rises = 0; oe_low = 0; latch = 0; latch_clk = 0; latch_after = 0;
        data_err = 0; inv_err = 0; addr_err = 0; timeout = 1;
        prev_clk = 1'b0; seen_low = 1'b0; prev_addr = addr_a;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (oe_a && seen_low) begin
                timeout = 0;
                break;
            end
            if (hclk_a && !prev_clk) begin
                got = {b_a[8:6], g_a[8:6], r_a[8:6], b_a[5:3], g_a[5:3], r_a[5:3],
                       b_a[2:0], g_a[2:0], r_a[2:0]};
                if (got != pat({3'(plane), 5'(row), 7'(rises)})) data_err++;
                rises++;
            end
            prev_clk = hclk_a;
            if (lat_a) begin
                latch++;
                if (hclk_a) latch_clk++;
                if (!hclk_a && rises == COLS) latch_after++;
                if (!oe_a) inv_err++;
            end
            if (addr_a != prev_addr && !oe_a) inv_err++;
            prev_addr = addr_a;
            if (addr_a != 5'(row)) addr_err++;
            if (!oe_a) begin
                oe_low++;
                seen_low = 1'b1;
            end
        end
    endtask

    initial begin
        int rises, oe_low, latch, latch_clk, latch_after, data_err, inv_err, addr_err, tmo;
        int bad, n, fd_count, t1, t2, seq_len, exp_next, oe_falls;
        logic [4:0] prev_addr;
        logic prev_oe, prev_hclk;
        int oe_tab[8] = '{16, 32, 64, 128, 256, 512, 1024, 2048};

        for (int p = 0; p < 8; p++)
            tbl[p] = '{start: (p == 0), lp: 1'b1, plane: p, row: 0, exp_rises: 120,
                       exp_oe_low: oe_tab[p], exp_latch: 2, exp_latch_clk: 0,
                       exp_latch_after: 2};
        tbl[8] = '{start: 1'b1, lp: 1'b0, plane: 0, row: 1, exp_rises: 120,
                   exp_oe_low: 16, exp_latch: 2, exp_latch_clk: 1, exp_latch_after: 0};

        rst_a = 1'b1; en_a = 1'b0; lp_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; lp_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_oe", oe_a, 1);
        check("rst_clk", hclk_a, 0);
        check("rst_latch", lat_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_fb_en", fb_en_a, 0);
        check("rst_rgb", {r_a, g_a, b_a}, 0);
        check("rst_frame_done", fd_a, 0);
        rst_a = 1'b0; rst_b = 1'b0;

        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (fb_en_a || !oe_a || hclk_a || lat_a || addr_a != 5'd0 || fd_a) bad++;
        end
        check("idle_quiet", bad, 0);

        // row 0 with LATCH_POS=1 (ENABLE pulsed, so the row ends in IDLE), then one plane of row 1 with LATCH_POS=0
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].start) begin
                if (i > 0) begin
                    bad = 0;
                    repeat (20) begin
                        @(negedge clk);
                        if (fb_en_a || !oe_a || addr_a != 5'(tbl[i].row)) bad++;
                    end
                    check($sformatf("v%0d_idle_after_row", i), bad, 0);
                end
                lp_a = tbl[i].lp;
                en_a = 1'b1;
                @(negedge clk);
                en_a = 1'b0;
            end
            run_plane(tbl[i].plane, tbl[i].row, rises, oe_low, latch, latch_clk, latch_after,
                      data_err, inv_err, addr_err, tmo);
            check($sformatf("v%0d_timeout", i), tmo, 0);
            check($sformatf("v%0d_clk_rises", i), rises, tbl[i].exp_rises);
            check($sformatf("v%0d_oe_low", i), oe_low, tbl[i].exp_oe_low);
            check($sformatf("v%0d_latch", i), latch, tbl[i].exp_latch);
            check($sformatf("v%0d_latch_clk", i), latch_clk, tbl[i].exp_latch_clk);
            check($sformatf("v%0d_latch_after", i), latch_after, tbl[i].exp_latch_after);
            check($sformatf("v%0d_data", i), data_err, 0);
            check($sformatf("v%0d_invariant", i), inv_err, 0);
            check($sformatf("v%0d_addr", i), addr_err, 0);
        end

        // async reset while OE is low in the next plane's DISPLAY
        n = 0;
        while (oe_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_display", oe_a, 0);
        #2 rst_a = 1'b1;
        #1;
        check("async_oe", oe_a, 1);
        check("async_latch", lat_a, 0);
        check("async_clk", hclk_a, 0);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        check("post_reset_addr", addr_a, 0);

        // small instance: full frames with LATCH_POS=0, 38 cycles per row x 8 rows
        lp_b = 1'b0;
        en_b = 1'b1;
        prev_addr = addr_b; exp_next = 1; fd_count = 0; t1 = 0; t2 = 0; seq_len = 0; bad = 0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (fd_b) begin
                fd_count++;
                if (fd_count == 1) t1 = k;
                else t2 = k;
            end
            if (addr_b != prev_addr) begin
                if (addr_b != 5'(exp_next) || fd_b != (addr_b == 5'd0) || !oe_b) bad++;
                exp_next = (exp_next + 1) % 8;
                seq_len++;
                prev_addr = addr_b;
            end
            if (fd_count == 2) break;
        end
        check("frame_done_count", fd_count, 2);
        check("frame_length", t2 - t1, 304);
        check("addr_steps", seq_len, 16);
        check("addr_sequence", bad, 0);

        // drop ENABLE during SHIFT of row 5: row finishes all planes, then idles at row 6
        n = 0;
        while (addr_b != 5'd5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reach_row5", addr_b, 5);
        n = 0;
        prev_hclk = hclk_b;
        while (!(hclk_b && !prev_hclk) && n < 100) begin
            prev_hclk = hclk_b;
            @(negedge clk);
            n++;
        end
        check("row5_shift_seen", hclk_b, 1);
        en_b = 1'b0;
        oe_falls = 0;
        prev_oe = oe_b;
        n = 0;
        while (addr_b == 5'd5 && n < 1000) begin
            @(negedge clk);
            if (prev_oe && !oe_b) oe_falls++;
            prev_oe = oe_b;
            n++;
        end
        check("row5_planes_shown", oe_falls, 3);
        check("stop_addr", addr_b, 6);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (fb_en_b || !oe_b || hclk_b || lat_b || addr_b != 5'd6) bad++;
        end
        check("stopped_idle", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
